nibble_serial_add: RTL
======================

# nibble_serial_add

Multi-cycle operand sequencer that feeds a 4-bit ripple adder one nibble per clock and assembles a WIDTH-bit sum. It sits directly upstream of the 4-bit adder stage. It latches two wide operands, presents them least-significant nibble first, and registers the carry between nibbles in a flip-flop. This lets the 74HC-style 4-bit adder serve 8/16/32-bit additions at one nibble per cycle.

## Interface
- NIBBLES, 4, operand width in nibbles (WIDTH = 4*NIBBLES); legal range 1..8

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain only
- start_valid  in  1  operands and cin are presented
- start_ready  out  1  block is idle and can accept; equals (state == IDLE)
- op_a  in  WIDTH  addend A, sampled on accept
- op_b  in  WIDTH  addend B, sampled on accept
- cin  in  1  carry-in to nibble 0, sampled on accept
- sum  out  WIDTH  registered result
- cout  out  1  carry out of the top nibble
- ovf  out  1  two's-complement overflow
- done_valid  out  1  result valid
- done_ready  in  1  consumer takes the result

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept on the edge where start_valid && start_ready.
  - Load shift registers a_sh <= op_a and b_sh <= op_b.
  - Load carry <= cin, idx <= 0, sum <= 0; go to RUN.
- RUN: each edge does the following.
  - The adder receives a_sh[3:0], b_sh[3:0] and carry.
  - Write sum[4*idx+3 : 4*idx] <= s4.
  - Update carry <= c4.
  - Shift a_sh and b_sh right by 4; increment idx.
  - When idx == NIBBLES-1, go to DONE and register cout <= c4.
  - Also register ovf <= (op_a MSB == op_b MSB) && (s4[3] != op_a MSB). Keep copies of the operand MSBs captured on accept.
- DONE:
  - done_valid = 1; sum, cout and ovf are held stable.
  - On done_valid && done_ready, go to IDLE.
  - start_valid is ignored while in RUN or DONE.
- Arithmetic: sum = (op_a + op_b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- Result registers retain their last value in IDLE; they are overwritten only by the next operation.

## Timing
- Reset (asynchronous, rst_n low):
  - state = IDLE, sum = 0, cout = 0, ovf = 0, done_valid = 0, carry = 0, idx = 0.
  - start_ready reads 1, but no accept occurs while rst_n is low.
- Latency: done_valid rises NIBBLES+1 edges after the accept edge (accept edge, NIBBLES RUN edges, now in DONE).
- Throughput: the next accept is possible no earlier than the edge after the done handshake, giving NIBBLES+2 cycles per operation with done_ready tied high.
- NIBBLES = 1: a single RUN cycle, then DONE.
- Reset asserted mid-RUN or mid-DONE:
  - Returns immediately to IDLE with all outputs at their reset values.
  - The partial result is discarded; no done_valid pulse appears.
- Handshake timing: done_ready may be high before done_valid; the handshake completes on the first DONE edge.

## Structure
- Shared package: state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and the NIBBLE_W = 4 constant.
- One sub-module, add4_cc: a combinational 4-bit adder with ports a[3:0], b[3:0], ci, s[3:0], co. It is instantiated once.
- idx width is $clog2(NIBBLES) with a minimum of 1.

## Test plan
- NIBBLES = 4, op_a = 16'hFFFF, op_b = 16'h0001, cin = 0 -> sum = 16'h0000, cout = 1, ovf = 0; done_valid high on edge 5 after accept.
- op_a = 16'h7FFF, op_b = 16'h0001, cin = 0 -> sum = 16'h8000, cout = 0, ovf = 1.
- op_a = 16'h1234, op_b = 16'h4321, cin = 1 -> sum = 16'h5556, cout = 0, ovf = 0.
- done_ready held low for 6 cycles in DONE with start_valid pulsed in that window -> sum, cout and ovf stable, start_ready = 0, no new accept; IDLE follows the handshake edge.
- rst_n pulsed low after 2 RUN edges of 16'hABCD + 16'h1111 -> outputs return to 0 asynchronously with no done_valid. A following 16'h0F0F + 16'hF0F0 gives sum = 16'hFFFF, cout = 0.
- Back-to-back operations with start_valid and done_ready held high -> accepts every 6 cycles; each result matches the reference model (op_a + op_b + cin).

Source files
------------

// File: rtl/nibble_serial_add_pkg.sv
// nibble_serial_add_pkg: shared FSM state encoding and nibble width
package nibble_serial_add_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/nibble_serial_add_add4_cc.sv
// add4_cc: combinational 4-bit ripple adder with carry in/out
module add4_cc
  import nibble_serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
endmodule

// File: rtl/nibble_serial_add.sv
// nibble_serial_add: feeds a 4-bit adder one nibble per clock to build a wide sum
module nibble_serial_add
  import nibble_serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   op_b,
  input  logic                          cin,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout,
  output logic                          ovf,
  output logic                          done_valid,
  input  logic                          done_ready
);
  localparam int WIDTH = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [NIBBLE_W-1:0] s4;
  logic c4;
  add4_cc u_add (
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (s4),
    .co (c4)
  );
  assign start_ready = state_q == IDLE;
  assign done_valid  = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end
  // accept operands, add one nibble per RUN cycle, hold the result until taken
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    case (state_q)
      IDLE: if (start_valid) begin
        state_d = RUN;
        a_d     = op_a;
        b_d     = op_b;
        carry_d = cin;
        idx_d   = '0;
        sum_d   = '0;
        a_msb_d = op_a[WIDTH-1];
        b_msb_d = op_b[WIDTH-1];
      end
      RUN: begin
        sum_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = s4;
        carry_d = c4;
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NIBBLES - 1)) begin
          state_d = DONE;
          cout_d  = c4;
          ovf_d   = (a_msb_q == b_msb_q) && (s4[NIBBLE_W-1] != a_msb_q);
        end
      end
      DONE: if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule
